// File: rtl/rr_encoder_arbiter_pkg.sv
// Shared types and constants for the 4-requester round-robin arbiter.
package arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t GRANT = 2'd1;
    localparam state_t TURN  = 2'd2;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/rr_encoder_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_encoder_arbiter_if;
    import arb_pkg::*;

    logic                enable;
    logic [NUM_REQ-1:0]  req;
    logic                owner_release;   // "release" is a reserved word
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    r;
    logic                grant_valid;
    logic                timeout;
    logic [9:0]          LEDR;

    modport master (output enable, req, owner_release,
                    input  grant, r, grant_valid, timeout, LEDR);
    modport slave  (input  enable, req, owner_release,
                    output grant, r, grant_valid, timeout, LEDR);
endinterface

// File: rtl/rr_encoder_arbiter_pick.sv
// Combinational rotate-priority select: first requester at or above ptr, wrapping.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   win,
    output logic               any
);
    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        win = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[ptr + IDX_W'(k)])
                win = ptr + IDX_W'(k);
        end
    end

    assign any = |req;
endmodule

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter FSM (IDLE/GRANT/TURN) with registered one-hot and encoded grant.
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles with a timeout pulse.
module rr_encoder_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input logic                 clk,
    input logic                 reset,
    rr_encoder_arbiter_if.slave bus
);
    if (MAX_HOLD < 2 || MAX_HOLD >= (1 << CNT_W)) begin : g_bad_param
        $error("MAX_HOLD must be >= 2 and fit in CNT_W bits");
    end

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [NUM_REQ-1:0] grant_q;
    logic               valid_q;
    logic               timeout_q;
    logic [IDX_W-1:0]   win;
    logic               any;
    logic               done;
    logic               revoke;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    // Owner finishes by explicit release or by dropping its request.
    assign done = bus.owner_release || !bus.req[owner];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;

    assign revoke = (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // Counter reads k-1 during the k-th grant cycle; release on the last cycle is not a timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            if (state == GRANT) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
                if (revoke && !done)
                    timeout_q <= 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign revoke    = 1'b0;
    assign timeout_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.enable && any) begin
                    state   <= GRANT;
                    owner   <= win;
                    grant_q <= onehot(win);
                    valid_q <= 1'b1;
                    ptr     <= win + IDX_W'(1);
                end
                GRANT: if (done || revoke) begin
                    state   <= TURN;
                    owner   <= '0;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                end
                TURN:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.r           = owner;
    assign bus.grant_valid = valid_q;
    assign bus.timeout     = timeout_q;
    assign bus.LEDR        = {ptr, timeout_q, valid_q, owner, grant_q};
endmodule
